axi_sram_slave: RTL

- AXI3 responder (slave) with a word-organised on-chip memory; the far end of the CPU's AXI master port.
- Serves as the memory/peripheral model the CPU top connects to in simulation and on FPGA.
- Independent read and write engines, each with one outstanding burst; supports FIXED/INCR bursts of up to 16 beats, 32-bit data.

---
 rtl/axi_sram_slave.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 responder over a word-organised SRAM with independent
// single-outstanding read and write burst engines (FIXED/INCR, up to 16 beats).
module axi_sram_slave #(
  parameter int          MEM_AW    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h1c000000
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  logic [31:0] mem [2**MEM_AW];

  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE_ADDR;
    return (o >> (MEM_AW + 2)) == 32'd0;
  endfunction

  function automatic logic [MEM_AW-1:0] widx(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE_ADDR;
    return o[MEM_AW+1:2];
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] s, input logic [1:0] b);
    return b == 2'b01 ? a + (32'd1 << s) : a;
  endfunction

  function automatic logic bad_burst(input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    return s > 3'd2 || b[1] || l > 8'd15;
  endfunction

  r_state_e    r_state_q, r_state_d;
  logic        arready_q, arready_d, rerr_q, rerr_d;
  logic [3:0]  rid_q, rid_d;
  logic [31:0] raddr_q, raddr_d;
  logic [7:0]  rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]  rsize_q, rsize_d;
  logic [1:0]  rburst_q, rburst_d;
  logic        r_beat_err;

  w_state_e    w_state_q, w_state_d;
  logic        awready_q, awready_d, werr_q, werr_d, bad_q, bad_d;
  logic [3:0]  bid_q, bid_d;
  logic [31:0] waddr_q, waddr_d;
  logic [7:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]  wsize_q, wsize_d;
  logic [1:0]  wburst_q, wburst_d;
  logic        w_beat, w_last_beat, w_beat_err, mem_we;
  logic        unused_ok;

  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  assign arready    = arready_q;
  assign rvalid     = r_state_q == R_DATA;
  assign r_beat_err = rerr_q | ~in_range(raddr_q);
  assign rdata      = rvalid && !r_beat_err ? mem[widx(raddr_q)] : 32'd0;
  assign rresp      = rvalid && r_beat_err ? 2'b10 : 2'b00;
  assign rlast      = rvalid && rcnt_q == rlen_q;
  assign rid        = rid_q;

  assign awready     = awready_q;
  assign wready      = w_state_q == W_DATA;
  assign w_beat      = wready & wvalid;
  assign w_last_beat = wcnt_q == wlen_q;
  assign w_beat_err  = werr_q | ~in_range(waddr_q);
  assign mem_we      = w_beat & ~w_beat_err;
  assign bvalid      = w_state_q == W_RESP;
  assign bresp       = bvalid && bad_q ? 2'b10 : 2'b00;
  assign bid         = bid_q;

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rerr_d    = rerr_q;
    rcnt_d    = rcnt_q;
    if (arvalid && arready_q) begin
      r_state_d = R_DATA;
      rid_d     = arid;
      raddr_d   = araddr;
      rlen_d    = arlen;
      rsize_d   = arsize;
      rburst_d  = arburst;
      rerr_d    = bad_burst(arlen, arsize, arburst);
      rcnt_d    = 8'd0;
    end
    if (rvalid && rready) begin
      raddr_d   = next_addr(raddr_q, rsize_q, rburst_q);
      rcnt_d    = rcnt_q + 8'd1;
      r_state_d = rlast ? R_IDLE : r_state_q;
    end
    arready_d = r_state_d == R_IDLE;
  end

  // wlast is only audited: the beat counter alone decides where the burst ends
  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    werr_d    = werr_q;
    wcnt_d    = wcnt_q;
    bad_d     = bad_q;
    if (awvalid && awready_q) begin
      w_state_d = W_DATA;
      bid_d     = awid;
      waddr_d   = awaddr;
      wlen_d    = awlen;
      wsize_d   = awsize;
      wburst_d  = awburst;
      werr_d    = bad_burst(awlen, awsize, awburst);
      wcnt_d    = 8'd0;
      bad_d     = 1'b0;
    end
    if (w_beat) begin
      waddr_d   = next_addr(waddr_q, wsize_q, wburst_q);
      wcnt_d    = wcnt_q + 8'd1;
      bad_d     = bad_q | w_beat_err | (wlast != w_last_beat);
      w_state_d = w_last_beat ? W_RESP : w_state_q;
    end
    if (bvalid && bready) w_state_d = W_IDLE;
    awready_d = w_state_d == W_IDLE;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rerr_q    <= 1'b0;
      rcnt_q    <= '0;
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      bid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      werr_q    <= 1'b0;
      wcnt_q    <= '0;
      bad_q     <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rerr_q    <= rerr_d;
      rcnt_q    <= rcnt_d;
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      bid_q     <= bid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      werr_q    <= werr_d;
      wcnt_q    <= wcnt_d;
      bad_q     <= bad_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem[widx(waddr_q)][8*i +: 8] <= wdata[8*i +: 8];
  end
endmodule
